// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM state
// encoding and requester identifiers.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

  // The requester that is not the given one.
  function automatic req_id_e otherReq(input req_id_e id);
    return (id == REQ_IF) ? REQ_D : REQ_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side request/ack signals and the memory-side access
// signals. The arbiter uses the slave view; the CPU core and memory array
// (or a bench) use the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = 10
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant picker. The current owner can be excluded so that the
// arbiter can re-arbitrate in the response cycle while that owner still
// holds its request high.
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIO = 1
) (
  input  logic    if_req_i,
  input  logic    d_req_i,
  input  logic    excl_en_i,
  input  req_id_e excl_id_i,
  input  req_id_e last_owner_i,
  input  logic    starve_sat_i,
  output logic    grant_valid_o,
  output req_id_e grant_id_o
);

  logic ifCand;
  logic dCand;

  // Starvation forces fetch; otherwise data priority or alternation on ties.
  always_comb begin
    ifCand        = if_req_i && !(excl_en_i && (excl_id_i == REQ_IF));
    dCand         = d_req_i  && !(excl_en_i && (excl_id_i == REQ_D));
    grant_valid_o = ifCand || dCand;
    grant_id_o    = REQ_IF;
    if (ifCand && dCand) begin
      if (starve_sat_i) begin
        grant_id_o = REQ_IF;
      end else if (DATA_PRIO != 0) begin
        grant_id_o = REQ_D;
      end else begin
        grant_id_o = otherReq(last_owner_i);
      end
    end else if (dCand) begin
      grant_id_o = REQ_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous-read memory between the instruction
// fetch port and the load/store data port. Each access takes an ISSUE cycle
// (registered memory strobe) and a RESP cycle (ack + read data). Data is
// preferred, with a starvation counter bounding how long fetch waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_AW       = 10,
  parameter int DATA_PRIO    = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q;
  req_id_e           owner_q;
  req_id_e           last_q;
  logic              ownerWe_q;
  logic [CNT_W-1:0]  starve_q;
  logic [CNT_W-1:0]  starve_d;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              grantValid;
  req_id_e           grantId;
  logic              grantWe;
  logic [MEM_AW-1:0] grantAddr;
  logic [DATA_W-1:0] grantWdata;
  logic              respActive;

  logic [ADDR_W-1:0] ifAddr;
  logic [ADDR_W-1:0] dAddr;
  logic              unusedAddrBits;

  assign ifAddr = bus.if_addr;
  assign dAddr  = bus.d_addr;

  // Byte offset and bits above the memory window are deliberately ignored.
  assign unusedAddrBits = ^{ifAddr[ADDR_W-1:MEM_AW+2], ifAddr[1:0],
                            dAddr[ADDR_W-1:MEM_AW+2], dAddr[1:0]};

  mem_arb_pick #(
    .DATA_PRIO(DATA_PRIO)
  ) u_pick (
    .if_req_i     (bus.if_req),
    .d_req_i      (bus.d_req),
    .excl_en_i    (state_q == ARB_RESP),
    .excl_id_i    (owner_q),
    .last_owner_i (last_q),
    .starve_sat_i (starve_q == CNT_MAX),
    .grant_valid_o(grantValid),
    .grant_id_o   (grantId)
  );

  // Select the winning request's address/data and the next starvation count.
  always_comb begin
    grantWe    = 1'b0;
    grantAddr  = ifAddr[MEM_AW+1:2];
    grantWdata = '0;
    starve_d   = starve_q;
    if (grantId == REQ_D) begin
      grantWe    = bus.d_we;
      grantAddr  = dAddr[MEM_AW+1:2];
      grantWdata = bus.d_wdata;
      if (bus.if_req && (starve_q != CNT_MAX)) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end else begin
      starve_d = '0;
    end
  end

  // Arbiter FSM; memory strobes are registered so no request reaches mem_* combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_IF;
      last_q      <= REQ_IF;
      ownerWe_q   <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE, ARB_RESP: begin
          if (grantValid) begin
            state_q     <= ARB_ISSUE;
            owner_q     <= grantId;
            last_q      <= grantId;
            ownerWe_q   <= grantWe;
            starve_q    <= starve_d;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grantWe;
            mem_addr_q  <= grantAddr;
            mem_wdata_q <= grantWdata;
          end else begin
            state_q  <= ARB_IDLE;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
          end
        end
        ARB_ISSUE: begin
          state_q  <= ARB_RESP;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
        default: begin
          state_q  <= ARB_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign respActive    = (state_q == ARB_RESP);
  assign bus.if_ack    = respActive && (owner_q == REQ_IF);
  assign bus.d_ack     = respActive && (owner_q == REQ_D);
  assign bus.if_rdata  = bus.if_ack ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (bus.d_ack && !ownerWe_q) ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (data priority and alternation),
// memory models preloaded with mem[i]=i*16, directed scenarios and random
// fetch/load/store traffic checked through per-port scoreboards.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic memInit;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10)) bus ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10)) bus2 ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10), .DATA_PRIO(1), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_AW(10), .DATA_PRIO(0), .STARVE_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave));

  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] refMem [1024];
  logic [31:0] ifExp [$];
  logic [31:0] dExp [$];
  int checkCount = 0;
  int passCount = 0;
  int dRun = 0;

  // Memory array models: registered address, read data the cycle after mem_en.
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 1024; i++) begin
        mem1[i] <= 32'(i * 16);
        mem2[i] <= 32'(i * 16);
      end
    end else begin
      if (bus.mem_en) begin
        if (bus.mem_we) mem1[bus.mem_addr] <= bus.mem_wdata;
        rd1 <= mem1[bus.mem_addr];
      end
      if (bus2.mem_en) begin
        if (bus2.mem_we) mem2[bus2.mem_addr] <= bus2.mem_wdata;
        rd2 <= mem2[bus2.mem_addr];
      end
    end
  end

  assign bus.mem_rdata  = rd1;
  assign bus2.mem_rdata = rd2;

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endfunction

  // Scoreboard monitor: pops the expected response whenever a port is acked.
  always @(negedge clk) begin
    if (!rst && !memInit) begin
      if (bus.mem_en) begin
        checkOutput("mem_access_matches_request",
          ((bus.if_req && bus.mem_addr == bus.if_addr[11:2] && !bus.mem_we) ||
           (bus.d_req && bus.mem_addr == bus.d_addr[11:2] && bus.mem_we == bus.d_we &&
            (!bus.d_we || bus.mem_wdata == bus.d_wdata))) ? 32'd1 : 32'd0, 32'd1);
      end
      if (bus.if_ack || bus.d_ack)
        checkOutput("single_ack", 32'(bus.if_ack & bus.d_ack), 32'd0);
      if (bus.if_ack) begin
        checkOutput("if_ack_expected", (ifExp.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (ifExp.size() != 0) checkOutput("if_rdata", bus.if_rdata, ifExp.pop_front());
        dRun = 0;
      end
      if (bus.d_ack) begin
        checkOutput("d_ack_expected", (dExp.size() != 0) ? 32'd1 : 32'd0, 32'd1);
        if (dExp.size() != 0) checkOutput("d_rdata", bus.d_rdata, dExp.pop_front());
        if (bus.if_req) begin
          dRun++;
          checkOutput("starve_bound", (dRun <= 3) ? 32'd1 : 32'd0, 32'd1);
        end
      end
    end
  end

  task automatic applyStimulusIf(input logic [9:0] word);
    logic [31:0] addr;
    int n;
    addr = $urandom();
    addr[11:2] = word;
    ifExp.push_back(refMem[word]);
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.if_ack && n < 100);
    if (!bus.if_ack) checkOutput("if_ack_timeout", 32'(bus.if_ack), 32'd1);
    @(posedge clk);
    #1 bus.if_req = 1'b0;
  endtask

  task automatic applyStimulusD(input logic we, input logic [9:0] word, input logic [31:0] wdata);
    logic [31:0] addr;
    int n;
    addr = $urandom();
    addr[11:2] = word;
    if (we) begin
      refMem[word] = wdata;
      dExp.push_back(32'd0);
    end else begin
      dExp.push_back(refMem[word]);
    end
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.d_ack && n < 100);
    if (!bus.d_ack) checkOutput("d_ack_timeout", 32'(bus.d_ack), 32'd1);
    @(posedge clk);
    #1 bus.d_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    req_id_e modelLast;
    req_id_e expOwner;
    int acks;

    rst = 1'b1;
    memInit = 1'b1;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus2.if_req = 0; bus2.if_addr = 0; bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = 0; bus2.d_wdata = 0;
    for (int i = 0; i < 1024; i++) refMem[i] = 32'(i * 16);
    repeat (3) @(posedge clk);
    @(negedge clk);
    memInit = 1'b0;
    rst = 1'b0;

    // Reset state
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_mem_en", 32'(bus.mem_en), 32'd0);
    checkOutput("reset_mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset_acks", 32'({bus.if_ack, bus.d_ack}), 32'd0);

    // Lone fetch of 0x8: ISSUE with word 2, then ack with 32
    @(negedge clk);
    ifExp.push_back(refMem[2]);
    bus.if_addr = 32'h8;
    bus.if_req  = 1'b1;
    @(posedge clk); #1;
    checkOutput("t1_mem_en", 32'(bus.mem_en), 32'd1);
    checkOutput("t1_mem_addr", 32'(bus.mem_addr), 32'd2);
    @(posedge clk); #1;
    checkOutput("t1_if_ack", 32'(bus.if_ack), 32'd1);
    checkOutput("t1_if_rdata", bus.if_rdata, 32'd32);
    checkOutput("t1_d_ack", 32'(bus.d_ack), 32'd0);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    checkOutput("t1_idle_after", 32'(bus.busy), 32'd0);

    // Reset during ISSUE of a store to 0x40: write must not commit
    @(negedge clk);
    bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678; bus.d_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6_mem_we_issue", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_mem_we_cleared", 32'(bus.mem_we), 32'd0);
    checkOutput("t6_mem_en_cleared", 32'(bus.mem_en), 32'd0);
    checkOutput("t6_busy_cleared", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.d_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_mem16_unchanged", mem1[16], 32'd256);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t6_no_ack", 32'(bus.d_ack), 32'd0);
    end

    // Store then load of 0x40
    @(negedge clk);
    applyStimulusD(1'b1, 10'd16, 32'hDEAD_BEEF);
    applyStimulusD(1'b0, 10'd16, 32'd0);
    checkOutput("t2_mem16", mem1[16], refMem[16]);

    // Simultaneous requests with data priority: D first, IF issued straight from RESP
    @(negedge clk);
    ifExp.push_back(refMem[1]);
    dExp.push_back(refMem[4]);
    bus.if_addr = 32'h4; bus.d_addr = 32'h10; bus.d_we = 1'b0;
    bus.if_req = 1'b1; bus.d_req = 1'b1;
    @(posedge clk); #1;
    checkOutput("t3_first_addr", 32'(bus.mem_addr), 32'd4);
    @(posedge clk); #1;
    checkOutput("t3_d_ack", 32'(bus.d_ack), 32'd1);
    checkOutput("t3_d_rdata", bus.d_rdata, 32'd64);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    checkOutput("t3_no_idle", 32'(bus.busy & bus.mem_en), 32'd1);
    checkOutput("t3_if_addr", 32'(bus.mem_addr), 32'd1);
    @(posedge clk); #1;
    checkOutput("t3_if_ack", 32'(bus.if_ack), 32'd1);
    checkOutput("t3_if_rdata", bus.if_rdata, 32'd16);
    @(posedge clk); #1;
    bus.if_req = 1'b0;

    // Fetch kept busy while data re-requests immediately, then random mixed traffic
    fork
      for (int i = 0; i < 8; i++) applyStimulusIf(10'($urandom_range(0, 511)));
      for (int i = 0; i < 16; i++) applyStimulusD(1'b0, 10'($urandom_range(0, 1023)), 32'd0);
    join
    fork
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 applyStimulusIf(10'($urandom_range(0, 511)));
      end
      for (int i = 0; i < 40; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 applyStimulusD(1'($urandom_range(0, 1)), 10'($urandom_range(512, 1023)), $urandom());
      end
    join
    fork
      for (int i = 0; i < 20; i++) applyStimulusD(1'b0, 10'($urandom_range(0, 1023)), 32'd0);
    join

    // Alternation instance: both requesting continuously
    @(negedge clk);
    bus2.if_addr = 32'h20; bus2.d_addr = 32'h30; bus2.d_we = 1'b0;
    bus2.if_req = 1'b1; bus2.d_req = 1'b1;
    modelLast = REQ_IF;
    acks = 0;
    for (int i = 0; i < 40 && acks < 8; i++) begin
      @(negedge clk);
      if (bus2.if_ack || bus2.d_ack) begin
        expOwner = (modelLast == REQ_IF) ? REQ_D : REQ_IF;
        checkOutput("t5_owner_is_d", 32'(bus2.d_ack), (expOwner == REQ_D) ? 32'd1 : 32'd0);
        if (bus2.d_ack) checkOutput("t5_d_rdata", bus2.d_rdata, 32'd192);
        else checkOutput("t5_if_rdata", bus2.if_rdata, 32'd128);
        modelLast = bus2.d_ack ? REQ_D : REQ_IF;
        acks++;
      end
    end
    checkOutput("t5_ack_count", 32'(acks), 32'd8);
    @(posedge clk); #1;
    bus2.if_req = 1'b0; bus2.d_req = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    checkOutput("if_queue_drained", 32'(ifExp.size()), 32'd0);
    checkOutput("d_queue_drained", 32'(dExp.size()), 32'd0);
    checkOutput("final_idle", 32'(bus.busy | bus2.busy), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
